// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit
// Description : Multicycle signed multiply/divide unit with HI/LO result
//               registers (MULT/DIV, read back through MFHI/MFLO).
//               Multiply uses radix-2 Booth, divide uses restoring division
//               on operand magnitudes followed by a sign fix-up.
// Ports       : clk        - system clock, rising edge
//               reset      - asynchronous active-high reset
//               a, b       - signed operands (multiplicand/dividend,
//                            multiplier/divisor)
//               mult_start - one-cycle strobe, start signed multiply
//               div_start  - one-cycle strobe, start signed divide
//               busy       - operation in progress
//               done       - one-cycle pulse, HI/LO valid
//               div_zero   - pulses with done when the divisor was zero
//               hi, lo     - result registers
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mult_start,
    input  logic             div_start,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_MULT = 3'd1;
    localparam logic [2:0] c_ST_DIV  = 3'd2;
    localparam logic [2:0] c_ST_FIX  = 3'd3;
    localparam logic [2:0] c_ST_DONE = 3'd4;

    localparam int                 c_CNT_W   = $clog2(WIDTH) + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_LAST    = c_CNT_W'(WIDTH - 1);

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_is_div;
    logic               r_dz;
    logic               r_a_neg;
    logic               r_b_neg;
    logic               r_b_zero;
    logic [WIDTH-1:0]   r_mcand;
    // Booth accumulator: {A (WIDTH+1 bits), Q (WIDTH bits), q(-1)}. The extra
    // A bit keeps A - M from overflowing when M is the most negative value.
    logic [2*WIDTH+1:0] r_acc;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_dvs;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic [WIDTH:0]     w_mcand_x;
    logic [WIDTH:0]     w_booth_sum;
    logic [2*WIDTH+1:0] w_acc_next;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;

    assign busy     = (r_state != c_ST_IDLE);
    assign done     = (r_state == c_ST_DONE);
    assign div_zero = done & r_dz;
    assign hi       = r_hi;
    assign lo       = r_lo;

    assign w_a_mag = a[WIDTH-1] ? -a : a;
    assign w_b_mag = b[WIDTH-1] ? -b : b;

    // Booth step: add/subtract multiplicand by {Q0, q(-1)}, then shift right
    // arithmetically across the whole accumulator.
    assign w_mcand_x = {r_mcand[WIDTH-1], r_mcand};
    always_comb begin
        w_booth_sum = r_acc[2*WIDTH+1:WIDTH+1];
        case (r_acc[1:0])
            2'b01:   w_booth_sum = r_acc[2*WIDTH+1:WIDTH+1] + w_mcand_x;
            2'b10:   w_booth_sum = r_acc[2*WIDTH+1:WIDTH+1] - w_mcand_x;
            default: w_booth_sum = r_acc[2*WIDTH+1:WIDTH+1];
        endcase
    end
    assign w_acc_next = {w_booth_sum[WIDTH], w_booth_sum, r_acc[WIDTH:1]};

    // Restoring divide step: shift the next dividend bit into the partial
    // remainder and subtract the divisor; a clear sign bit means it fit.
    assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_dvs};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (mult_start) begin
                    w_next_state = c_ST_MULT;
                end else if (div_start) begin
                    w_next_state = c_ST_DIV;
                end
            end
            c_ST_MULT: begin
                if (r_cnt == c_LAST) begin
                    w_next_state = c_ST_FIX;
                end
            end
            c_ST_DIV: begin
                if ((r_cnt == '0) && r_b_zero) begin
                    w_next_state = c_ST_DONE;
                end else if (r_cnt == c_LAST) begin
                    w_next_state = c_ST_FIX;
                end
            end
            // FIX is the shared result-write state for both operations.
            c_ST_FIX:  w_next_state = c_ST_DONE;
            c_ST_DONE: w_next_state = c_ST_IDLE;
            default:   w_next_state = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_dz     <= 1'b0;
            r_a_neg  <= 1'b0;
            r_b_neg  <= 1'b0;
            r_b_zero <= 1'b0;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_dvs    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (mult_start) begin
                        r_is_div <= 1'b0;
                        r_dz     <= 1'b0;
                        r_cnt    <= '0;
                        r_mcand  <= a;
                        r_acc    <= {{(WIDTH+1){1'b0}}, b, 1'b0};
                    end else if (div_start) begin
                        r_is_div <= 1'b1;
                        r_dz     <= 1'b0;
                        r_cnt    <= '0;
                        r_a_neg  <= a[WIDTH-1];
                        r_b_neg  <= b[WIDTH-1];
                        r_b_zero <= (b == '0);
                        r_quo    <= w_a_mag;
                        r_dvs    <= w_b_mag;
                        r_rem    <= '0;
                    end
                end
                c_ST_MULT: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + c_CNT_ONE;
                end
                c_ST_DIV: begin
                    if ((r_cnt == '0) && r_b_zero) begin
                        r_dz <= 1'b1;
                    end else begin
                        if (!w_diff[WIDTH]) begin
                            r_rem <= w_diff[WIDTH-1:0];
                            r_quo <= {r_quo[WIDTH-2:0], 1'b1};
                        end else begin
                            r_rem <= w_rem_sh[WIDTH-1:0];
                            r_quo <= {r_quo[WIDTH-2:0], 1'b0};
                        end
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                c_ST_FIX: begin
                    if (r_is_div) begin
                        // Quotient truncates toward zero; remainder follows
                        // the dividend's sign.
                        r_lo <= (r_a_neg ^ r_b_neg) ? -r_quo : r_quo;
                        r_hi <= r_a_neg ? -r_rem : r_rem;
                    end else begin
                        r_hi <= r_acc[2*WIDTH:WIDTH+1];
                        r_lo <= r_acc[WIDTH:1];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Self-checking bench for mult_div_unit. Expected HI/LO come
//               from plain 64-bit signed arithmetic; timing expectations
//               come from the documented latencies.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

    localparam int W = 32;

    logic         clk        = 1'b0;
    logic         reset      = 1'b1;
    logic [W-1:0] a          = '0;
    logic [W-1:0] b          = '0;
    logic         mult_start = 1'b0;
    logic         div_start  = 1'b0;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .a          (a),
        .b          (b),
        .mult_start (mult_start),
        .div_start  (div_start),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [W-1:0] m_hi    = '0;
    logic [W-1:0] m_lo    = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: mode 0 = multiply, 1 = divide, 2 = both strobes (multiply wins).
    task automatic model(input int mode, input logic [W-1:0] x, input logic [W-1:0] y);
        logic signed [63:0] sx;
        logic signed [63:0] sy;
        logic signed [63:0] r;
        sx = {{32{x[W-1]}}, x};
        sy = {{32{y[W-1]}}, y};
        if (mode != 1) begin
            r    = sx * sy;
            m_hi = r[63:32];
            m_lo = r[31:0];
        end else if (y != '0) begin
            r    = sx / sy;
            m_lo = r[31:0];
            r    = sx % sy;
            m_hi = r[31:0];
        end
    endtask

    // inj > 0 pulses div_start so that it is sampled at edge E<inj>.
    task automatic run_op(input int mode, input logic [W-1:0] x, input logic [W-1:0] y, input int inj);
        int edges;
        int busy_cyc;
        int lat;
        bit dz;
        dz  = (mode == 1) && (y == '0);
        lat = dz ? 1 : 33;
        model(mode, x, y);
        @(negedge clk);
        a          = x;
        b          = y;
        mult_start = (mode != 1);
        div_start  = (mode != 0);
        @(negedge clk);
        mult_start = 1'b0;
        div_start  = 1'b0;
        a          = $urandom;
        b          = $urandom;
        edges      = 0;
        busy_cyc   = busy ? 1 : 0;
        while (!done && edges < 40) begin
            div_start = (edges == inj - 1);
            @(negedge clk);
            edges++;
            if (busy) busy_cyc++;
        end
        div_start = 1'b0;
        check("latency", edges, lat);
        check("div_zero", div_zero, dz);
        check("hi", hi, m_hi);
        check("lo", lo, m_lo);
        @(negedge clk);
        check("done_single_pulse", done, 0);
        check("busy_cycles", busy_cyc, lat + 1);
        check("idle_after", busy, 0);
    endtask

    initial begin
        int           mode;
        logic [W-1:0] x;
        logic [W-1:0] y;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dz", div_zero, 0);
        reset = 1'b0;

        // Directed multiplies
        run_op(0, 32'd7, 32'hFFFFFFFD, 0);
        check("mul7x-3_hi", hi, 32'hFFFFFFFF);
        check("mul7x-3_lo", lo, 32'hFFFFFFEB);
        run_op(0, 32'h80000000, 32'h80000000, 0);
        check("mulmin_hi", hi, 32'h40000000);
        check("mulmin_lo", lo, 32'h00000000);

        // Directed divides
        run_op(1, 32'hFFFFFFF9, 32'd2, 0);
        check("div-7/2_lo", lo, 32'hFFFFFFFD);
        check("div-7/2_hi", hi, 32'hFFFFFFFF);
        run_op(1, 32'd7, 32'hFFFFFFFE, 0);
        check("div7/-2_lo", lo, 32'hFFFFFFFD);
        check("div7/-2_hi", hi, 32'h00000001);
        run_op(1, 32'd5, 32'd0, 0);
        check("divzero_lo_kept", lo, 32'hFFFFFFFD);
        check("divzero_hi_kept", hi, 32'h00000001);
        run_op(1, 32'h80000000, 32'hFFFFFFFF, 0);
        check("divovf_lo", lo, 32'h80000000);
        check("divovf_hi", hi, 32'h00000000);

        // Both strobes: multiply wins
        run_op(2, 32'd6, 32'd3, 0);
        check("both_lo", lo, 32'd18);

        // div_start during a multiply is ignored
        run_op(0, 32'h0001_2345, 32'hFFFF_1234, 10);

        // Randomized operations
        for (int i = 0; i < 14; i++) begin
            mode = $urandom_range(0, 1);
            x    = $urandom;
            y    = $urandom;
            if ($urandom_range(0, 2) == 0) y = $urandom_range(1, 9);
            if ($urandom_range(0, 2) == 0) y = -y;
            if ($urandom_range(0, 6) == 0) y = '0;
            run_op(mode, x, y, 0);
        end

        // Reset in the middle of a divide
        run_op(0, 32'h1234, 32'h5678, 0);
        @(negedge clk);
        a         = 32'd1000;
        b         = 32'd7;
        div_start = 1'b1;
        @(negedge clk);
        div_start = 1'b0;
        repeat (14) @(negedge clk);
        @(posedge clk);
        reset = 1'b1;
        #1;
        check("midrst_hi", hi, 0);
        check("midrst_lo", lo, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_dz", div_zero, 0);
        @(negedge clk);
        reset = 1'b0;
        m_hi  = '0;
        m_lo  = '0;
        run_op(0, 32'd3, 32'd4, 0);
        check("post_rst_lo", lo, 32'd12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
